// File: rtl/memoria_respondedor.sv
// Memory-side responder: small register-file RAM with one-cycle writes and
// fixed-latency reads, plus busy/erro handshake for the control unit.
module memoria_respondedor #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned ADDR_WIDTH   = 4,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rd,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] endereco,
    input  logic [DATA_WIDTH-1:0] dataIn,
    output logic [DATA_WIDTH-1:0] dataOut,
    output logic                  dataValid,
    output logic                  writeAck,
    output logic                  busy,
    output logic                  erro
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam logic [3:0] CntLoad = 4'(READ_LATENCY - 1);

    typedef enum logic [0:0] {Ocioso, Leitura} state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   dout_q, dout_d;
    logic                    dv_q, dv_d;
    logic                    wa_q, wa_d;
    logic                    busy_q, busy_d;
    logic                    erro_q, erro_d;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_q [Depth];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        dv_d    = 1'b0;
        wa_d    = 1'b0;
        busy_d  = busy_q;
        erro_d  = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            Ocioso: begin
                if (we) begin
                    mem_we = 1'b1;
                    wa_d   = 1'b1;
                end else if (rd) begin
                    addr_d  = endereco;
                    cnt_d   = CntLoad;
                    busy_d  = 1'b1;
                    state_d = Leitura;
                end
            end
            Leitura: begin
                // Commands during a read are dropped, including on the completing edge.
                erro_d = rd | we;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    dout_d  = mem_q[addr_q];
                    dv_d    = 1'b1;
                    busy_d  = 1'b0;
                    state_d = Ocioso;
                end
            end
            default: state_d = Ocioso;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= Ocioso;
            cnt_q   <= '0;
            addr_q  <= '0;
            dout_q  <= '0;
            dv_q    <= 1'b0;
            wa_q    <= 1'b0;
            busy_q  <= 1'b0;
            erro_q  <= 1'b0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            dv_q    <= dv_d;
            wa_q    <= wa_d;
            busy_q  <= busy_d;
            erro_q  <= erro_d;
            if (mem_we) begin
                mem_q[endereco] <= dataIn;
            end
        end
    end

    assign dataOut   = dout_q;
    assign dataValid = dv_q;
    assign writeAck  = wa_q;
    assign busy      = busy_q;
    assign erro      = erro_q;

endmodule

// File: tb/tb_memoria_respondedor.sv
// Directed bench: vector table for the latency-2 responder, hand sequences for
// reset-abort and a latency-1 instance.
module tb_memoria_respondedor;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       rd = 1'b0, we = 1'b0;
    logic [3:0] endereco = '0;
    logic [7:0] dataIn = '0;
    logic [7:0] dataOut;
    logic       dataValid, writeAck, busy, erro;

    logic       rd1 = 1'b0, we1 = 1'b0;
    logic [3:0] end1 = '0;
    logic [7:0] din1 = '0;
    logic [7:0] dout1;
    logic       dv1, wa1, busy1, erro1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rd;
        logic       we;
        logic [3:0] addr;
        logic [7:0] din;
        logic [7:0] e_dout;
        logic       e_dv;
        logic       e_wa;
        logic       e_busy;
        logic       e_erro;
    } vec_t;

    vec_t tbl[$];

    memoria_respondedor #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(2)) dut (
        .clock(clock), .reset(reset), .rd(rd), .we(we), .endereco(endereco),
        .dataIn(dataIn), .dataOut(dataOut), .dataValid(dataValid),
        .writeAck(writeAck), .busy(busy), .erro(erro)
    );

    memoria_respondedor #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(1)) dut1 (
        .clock(clock), .reset(reset), .rd(rd1), .we(we1), .endereco(end1),
        .dataIn(din1), .dataOut(dout1), .dataValid(dv1),
        .writeAck(wa1), .busy(busy1), .erro(erro1)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic add(input logic r, input logic w, input logic [3:0] a, input logic [7:0] d,
                       input logic [7:0] eo, input logic edv, input logic ewa,
                       input logic eb, input logic ee);
        vec_t v;
        v.rd = r; v.we = w; v.addr = a; v.din = d;
        v.e_dout = eo; v.e_dv = edv; v.e_wa = ewa; v.e_busy = eb; v.e_erro = ee;
        tbl.push_back(v);
    endtask

    task automatic check_main(input string tag, input logic [7:0] eo, input logic edv,
                              input logic ewa, input logic eb, input logic ee);
        chk({tag, " dataOut"}, dataOut, eo);
        chk({tag, " dataValid"}, 8'(dataValid), 8'(edv));
        chk({tag, " writeAck"}, 8'(writeAck), 8'(ewa));
        chk({tag, " busy"}, 8'(busy), 8'(eb));
        chk({tag, " erro"}, 8'(erro), 8'(ee));
    endtask

    initial begin
        // Table: inputs applied before an edge, outputs expected just after it.
        add(0, 1, 4'h3, 8'hA5, 8'h00, 0, 1, 0, 0);
        add(1, 0, 4'h3, 8'h00, 8'h00, 0, 0, 1, 0);
        add(0, 0, 4'h0, 8'h00, 8'h00, 0, 0, 1, 0);
        add(0, 0, 4'h0, 8'h00, 8'hA5, 1, 0, 0, 0);
        add(1, 1, 4'h7, 8'h3C, 8'hA5, 0, 1, 0, 0);
        add(1, 0, 4'h7, 8'h00, 8'hA5, 0, 0, 1, 0);
        add(0, 0, 4'h0, 8'h00, 8'hA5, 0, 0, 1, 0);
        add(0, 0, 4'h0, 8'h00, 8'h3C, 1, 0, 0, 0);
        add(1, 0, 4'h3, 8'h00, 8'h3C, 0, 0, 1, 0);
        add(0, 1, 4'h3, 8'hFF, 8'h3C, 0, 0, 1, 1);
        add(0, 0, 4'h0, 8'h00, 8'hA5, 1, 0, 0, 0);
        add(1, 0, 4'h3, 8'h00, 8'hA5, 0, 0, 1, 0);
        add(0, 0, 4'h0, 8'h00, 8'hA5, 0, 0, 1, 0);
        add(1, 0, 4'h5, 8'h00, 8'hA5, 1, 0, 0, 1);
        add(0, 0, 4'h0, 8'h00, 8'hA5, 0, 0, 0, 0);
        add(1, 1, 4'h0, 8'h11, 8'hA5, 0, 1, 0, 0);
        add(1, 1, 4'hF, 8'h22, 8'hA5, 0, 1, 0, 0);
        add(1, 0, 4'hF, 8'h00, 8'hA5, 0, 0, 1, 0);
        add(0, 0, 4'h0, 8'h00, 8'hA5, 0, 0, 1, 0);
        add(0, 0, 4'h0, 8'h00, 8'h22, 1, 0, 0, 0);

        #12;
        check_main("reset", 8'h00, 0, 0, 0, 0);
        chk("reset busy1", 8'(busy1), 8'h00);
        @(posedge clock);
        #1 reset = 1'b0;

        // Every address reads zero after reset, with two busy cycles.
        for (int a = 0; a < 16; a++) begin
            rd = 1'b1; endereco = 4'(a);
            step();
            rd = 1'b0;
            chk($sformatf("rd%0d busy0", a), 8'(busy), 8'h01);
            chk($sformatf("rd%0d dv0", a), 8'(dataValid), 8'h00);
            step();
            chk($sformatf("rd%0d busy1", a), 8'(busy), 8'h01);
            chk($sformatf("rd%0d dv1", a), 8'(dataValid), 8'h00);
            step();
            chk($sformatf("rd%0d busy2", a), 8'(busy), 8'h00);
            chk($sformatf("rd%0d dv2", a), 8'(dataValid), 8'h01);
            chk($sformatf("rd%0d data", a), dataOut, 8'h00);
        end

        foreach (tbl[i]) begin
            rd = tbl[i].rd; we = tbl[i].we; endereco = tbl[i].addr; dataIn = tbl[i].din;
            step();
            check_main($sformatf("vec%0d", i), tbl[i].e_dout, tbl[i].e_dv, tbl[i].e_wa,
                       tbl[i].e_busy, tbl[i].e_erro);
        end
        rd = 1'b0; we = 1'b0;

        // Reset in the middle of a read aborts it and clears everything at once.
        rd = 1'b1; endereco = 4'h3;
        step();
        rd = 1'b0;
        chk("abort busy before", 8'(busy), 8'h01);
        reset = 1'b1;
        #1;
        chk("abort busy", 8'(busy), 8'h00);
        chk("abort dataOut", dataOut, 8'h00);
        step();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("abort no dv %0d", k), 8'(dataValid), 8'h00);
            chk($sformatf("abort idle %0d", k), 8'(busy), 8'h00);
        end
        rd = 1'b1; endereco = 4'h3;
        step();
        rd = 1'b0;
        step();
        step();
        check_main("post-reset rd3", 8'h00, 1, 0, 0, 0);

        // Latency-1 instance: reads every other cycle complete one edge later.
        we1 = 1'b1; end1 = 4'h1; din1 = 8'h5A;
        step();
        chk("l1 wa", 8'(wa1), 8'h01);
        end1 = 4'h2; din1 = 8'hC3;
        step();
        we1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            rd1 = 1'b1; end1 = (k % 2 == 0) ? 4'h1 : 4'h2;
            step();
            rd1 = 1'b0;
            chk($sformatf("l1 rd%0d busy", k), 8'(busy1), 8'h01);
            chk($sformatf("l1 rd%0d dv early", k), 8'(dv1), 8'h00);
            chk($sformatf("l1 rd%0d erro a", k), 8'(erro1), 8'h00);
            step();
            chk($sformatf("l1 rd%0d dv", k), 8'(dv1), 8'h01);
            chk($sformatf("l1 rd%0d data", k), dout1, (k % 2 == 0) ? 8'h5A : 8'hC3);
            chk($sformatf("l1 rd%0d idle", k), 8'(busy1), 8'h00);
            chk($sformatf("l1 rd%0d erro b", k), 8'(erro1), 8'h00);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
